// File: rtl/flash_byte_reader_if.sv
// Avalon-MM pipelined read channel between flash_byte_reader (master) and the
// 32-bit flash (slave).
interface flash_byte_reader_if #(
    parameter int ADDR_W = 21
);
    logic              flash_mem_read;
    logic [ADDR_W-3:0] flash_mem_address;
    logic [3:0]        flash_mem_byteenable;
    logic              flash_mem_waitrequest;
    logic [31:0]       flash_mem_readdata;
    logic              flash_mem_readdatavalid;

    modport master (
        output flash_mem_read,
        output flash_mem_address,
        output flash_mem_byteenable,
        input  flash_mem_waitrequest,
        input  flash_mem_readdata,
        input  flash_mem_readdatavalid
    );

    modport slave (
        input  flash_mem_read,
        input  flash_mem_address,
        input  flash_mem_byteenable,
        output flash_mem_waitrequest,
        output flash_mem_readdata,
        output flash_mem_readdatavalid
    );
endinterface

// File: rtl/flash_byte_reader.sv
// Turns a level-type byte-read request into one Avalon-MM read of the 32-bit flash
// and returns the addressed byte. Optional last-word cache: FLASH_WORD_CACHE_EN.
module flash_byte_reader #(
    parameter int ADDR_W         = 21,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_all,
    input  logic              read_start,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [7:0]        data_out,
    output logic              finish_read,
    output logic              read_error,
    flash_byte_reader_if.master flash
);

    localparam int                CNT_W        = 10;
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Bit 0 drives the read strobe and bit 1 the finish pulse, straight from flops.
    typedef enum logic [3:0] {
        S_IDLE       = 4'b0000,
        S_ISSUE      = 4'b0001,
        S_DONE       = 4'b0010,
        S_WAIT_VALID = 4'b0100,
        S_RELEASE    = 4'b1000
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [7:0]        data_q,  data_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

`ifdef FLASH_WORD_CACHE_EN
    logic              cache_valid_q, cache_valid_d;
    logic [31:0]       cache_word_q,  cache_word_d;
    logic [ADDR_W-3:0] cache_waddr_q, cache_waddr_d;
    logic              cache_hit;

    assign cache_hit = cache_valid_q && (cache_waddr_q == addr_in[ADDR_W-1:2]);
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        error_d = error_q;
        cnt_d   = cnt_q;
`ifdef FLASH_WORD_CACHE_EN
        cache_valid_d = cache_valid_q;
        cache_word_d  = cache_word_q;
        cache_waddr_d = cache_waddr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (read_start) begin
                    addr_d  = addr_in;
                    state_d = S_ISSUE;
`ifdef FLASH_WORD_CACHE_EN
                    if (cache_hit) begin
                        data_d  = pick_byte(cache_word_q, addr_in[1:0]);
                        state_d = S_DONE;
                    end
`endif
                end
            end

            S_ISSUE: begin
                if (!flash.flash_mem_waitrequest) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_VALID;
                end
            end

            S_WAIT_VALID: begin
                if (flash.flash_mem_readdatavalid) begin
                    data_d  = pick_byte(flash.flash_mem_readdata, addr_q[1:0]);
                    state_d = S_DONE;
`ifdef FLASH_WORD_CACHE_EN
                    cache_valid_d = 1'b1;
                    cache_word_d  = flash.flash_mem_readdata;
                    cache_waddr_d = addr_q[ADDR_W-1:2];
`endif
                end else if (cnt_q == TIMEOUT_LAST) begin
                    data_d  = '0;
                    error_d = 1'b1;
                    state_d = S_DONE;
`ifdef FLASH_WORD_CACHE_EN
                    cache_valid_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: state_d = S_RELEASE;

            // Waiting for the request to drop keeps one read per request.
            S_RELEASE: begin
                if (!read_start) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_all) begin
        if (!reset_all) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FLASH_WORD_CACHE_EN
    always_ff @(posedge clk or negedge reset_all) begin
        if (!reset_all) cache_valid_q <= 1'b0;
        else            cache_valid_q <= cache_valid_d;
    end

    // NOTE: the cached word and its address need no reset; the valid bit gates them.
    always_ff @(posedge clk) begin
        cache_word_q  <= cache_word_d;
        cache_waddr_q <= cache_waddr_d;
    end
`endif

    assign flash.flash_mem_read       = state_q[0];
    assign flash.flash_mem_byteenable = {4{state_q[0]}};
    assign flash.flash_mem_address    = addr_q[ADDR_W-1:2];
    assign finish_read                = state_q[1];
    assign data_out                   = data_q;
    assign read_error                 = error_q;

endmodule

// File: tb/tb_flash_byte_reader.sv
// Randomized bench for flash_byte_reader: a behavioural flash slave plus a
// transaction-level model of latency, selected byte, read count and error flag.
module tb_flash_byte_reader;

    localparam int ADDR_W  = 21;
    localparam int TIMEOUT = 8;
`ifdef FLASH_WORD_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_all;
    logic              read_start;
    logic [ADDR_W-1:0] addr_in;
    logic [7:0]        data_out;
    logic              finish_read;
    logic              read_error;

    flash_byte_reader_if #(.ADDR_W(ADDR_W)) flash_bus ();

    flash_byte_reader #(
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_all  (reset_all),
        .read_start (read_start),
        .addr_in    (addr_in),
        .data_out   (data_out),
        .finish_read(finish_read),
        .read_error (read_error),
        .flash      (flash_bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  m_data        = 8'h00;
    bit          m_err         = 1'b0;
    bit          m_cache_valid = 1'b0;
    logic [18:0] m_cache_waddr = '0;
    logic [31:0] m_cache_word  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request: ws stall cycles on the read, readdatavalid lat cycles after the
    // accepted read, read_start held hold cycles past the finish pulse.
    task automatic do_read(input logic [20:0] a, input int ws, input int lat,
                           input logic [31:0] word, input int hold);
        bit         hit, tmo;
        int         exp_fin, exp_reads, exp_rdc;
        logic [7:0] exp_byte;
        int         fin_cyc = -1, fin_cnt = 0, accepts = 0, rd_cycles = 0;
        int         acc_cyc = -1, stall_left = ws;

        hit       = CACHE_EN && m_cache_valid && (m_cache_waddr == a[20:2]);
        tmo       = !hit && (lat > TIMEOUT);
        exp_fin   = hit ? 1 : (tmo ? ws + 2 + TIMEOUT : ws + 2 + lat);
        exp_reads = hit ? 0 : 1;
        exp_rdc   = hit ? 0 : ws + 1;
        if (hit)      exp_byte = 8'(m_cache_word >> (8 * a[1:0]));
        else if (tmo) exp_byte = 8'h00;
        else          exp_byte = 8'(word >> (8 * a[1:0]));

        @(posedge clk); #1;
        read_start = 1'b1;
        addr_in    = a;
        flash_bus.flash_mem_waitrequest = 1'b0;

        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk); #1;
            addr_in = 21'($urandom);
            if (finish_read) begin
                fin_cnt++;
                if (fin_cyc < 0) fin_cyc = cyc;
            end
            read_start = (fin_cyc < 0) || (cyc <= fin_cyc + hold);
            if (flash_bus.flash_mem_read) begin
                rd_cycles++;
                check("byteenable", 32'(flash_bus.flash_mem_byteenable), 32'h0000000f);
                check("word_addr", 32'(flash_bus.flash_mem_address), 32'(a[20:2]));
                if (stall_left > 0) begin
                    flash_bus.flash_mem_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    flash_bus.flash_mem_waitrequest = 1'b0;
                    accepts++;
                    acc_cyc = cyc;
                end
            end else begin
                flash_bus.flash_mem_waitrequest = 1'($urandom);
            end
            flash_bus.flash_mem_readdatavalid = (acc_cyc >= 0) && (cyc == acc_cyc + lat);
            flash_bus.flash_mem_readdata = flash_bus.flash_mem_readdatavalid ? word : $urandom;
            if (fin_cyc >= 0 && cyc >= fin_cyc + hold + 3) break;
        end

        @(posedge clk); #1;
        read_start = 1'b0;
        flash_bus.flash_mem_readdatavalid = 1'b0;
        flash_bus.flash_mem_waitrequest   = 1'b0;

        if (hit) begin
            m_data = exp_byte;
        end else if (tmo) begin
            m_data        = 8'h00;
            m_err         = 1'b1;
            m_cache_valid = 1'b0;
        end else begin
            m_data        = exp_byte;
            m_cache_valid = 1'b1;
            m_cache_waddr = a[20:2];
            m_cache_word  = word;
        end

        check("finish_latency", 32'(fin_cyc), 32'(exp_fin));
        check("finish_pulses", 32'(fin_cnt), 32'd1);
        check("flash_reads", 32'(accepts), 32'(exp_reads));
        check("read_cycles", 32'(rd_cycles), 32'(exp_rdc));
        check("data_out", 32'(data_out), 32'(m_data));
        check("read_error", 32'(read_error), 32'(m_err));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"},  32'(data_out), 32'h0);
        check({tag, "_fin"},   32'(finish_read), 32'h0);
        check({tag, "_err"},   32'(read_error), 32'h0);
        check({tag, "_read"},  32'(flash_bus.flash_mem_read), 32'h0);
        check({tag, "_addr"},  32'(flash_bus.flash_mem_address), 32'h0);
        check({tag, "_be"},    32'(flash_bus.flash_mem_byteenable), 32'h0);
    endtask

    // Reset asserted while waiting for read data; the reply that follows is stale.
    task automatic reset_mid(input logic [31:0] word);
        logic [20:0] a;
        a = {~m_cache_waddr, 2'b01};
        @(posedge clk); #1;
        read_start = 1'b1;
        addr_in    = a;
        flash_bus.flash_mem_waitrequest = 1'b0;
        @(posedge clk); #1;
        check("rst_issue", 32'(flash_bus.flash_mem_read), 32'h1);
        @(posedge clk); #1;
        check("rst_wait_read", 32'(flash_bus.flash_mem_read), 32'h0);
        check("rst_wait_fin", 32'(finish_read), 32'h0);
        #2 reset_all = 1'b0;
        #1 check_reset_values("rst_mid");
        read_start = 1'b0;
        m_data = 8'h00;
        m_err = 1'b0;
        m_cache_valid = 1'b0;
        @(posedge clk); #1;
        reset_all = 1'b1;
        @(posedge clk); #1;
        flash_bus.flash_mem_readdatavalid = 1'b1;
        flash_bus.flash_mem_readdata      = word;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            flash_bus.flash_mem_readdatavalid = 1'b0;
            check("rst_no_finish", 32'(finish_read), 32'h0);
            check("rst_no_read", 32'(flash_bus.flash_mem_read), 32'h0);
        end
        check("rst_stale_data", 32'(data_out), 32'h0);
    endtask

    logic [20:0] r_addr;

    initial begin
        reset_all  = 1'b1;
        read_start = 1'b0;
        addr_in    = '0;
        flash_bus.flash_mem_waitrequest   = 1'b0;
        flash_bus.flash_mem_readdata      = '0;
        flash_bus.flash_mem_readdatavalid = 1'b0;
        #2 reset_all = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        reset_all = 1'b1;

        do_read(21'h000002, 0, 1, 32'hA1B2C3D4, 0);
        do_read(21'h1FFFFF, 4, 2, 32'h5E6F7A8B, 0);
        do_read(21'h0ABCD1, 0, 2, 32'hCAFEF00D, 3);
        do_read(21'h012340, 0, TIMEOUT, 32'h77665544, 0);
        do_read(21'h0F0F03, 1, 10, 32'hDEADBEEF, 0);
        reset_mid(32'h13572468);
        do_read(21'h000004, 0, 1, 32'h11223344, 0);
        do_read(21'h000005, 0, 3, 32'h99887766, 0);

        for (int n = 0; n < 24; n++) begin
            r_addr = 21'($urandom);
            if ($urandom_range(0, 2) == 0) r_addr = {m_cache_waddr, 2'($urandom)};
            do_read(r_addr, $urandom_range(0, 4), $urandom_range(1, 10), $urandom,
                    $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
